button_conditioner: RTL and testbench



---
 rtl/clock_pkg.sv | 21 ++
 rtl/button_debounce.sv | 63 ++++++
 rtl/button_conditioner.sv | 101 ++++++++++
 tb/tb_button_conditioner.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the clock user project: cycle counts at the nominal
// system clock and the display/set mode encoding consumed by the core.
package clock_pkg;

   localparam int unsigned ClockFreqHz           = 10_000_000;
   localparam int unsigned DebounceCyclesDefault = 100_000;    // 10 ms
   localparam int unsigned HoldCyclesDefault     = 5_000_000;  // 500 ms
   localparam int unsigned RepeatCyclesDefault   = 1_000_000;  // 100 ms

   typedef enum logic [1:0] {
      ModeShowTime,
      ModeSetHours,
      ModeSetMinutes,
      ModeSetSeconds
   } clock_mode_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter, stable level and
// rise detection. The rise strobe is presented one cycle early (rise_next) so
// the parent can register its pulse on the same edge the level changes.
module button_debounce
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic level_next,
   output logic rise_next
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;

   // Bring the asynchronous pad level into the clock domain.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive cycles of disagreement; any agreement restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntMax) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounce state.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level      = level_q;
   assign level_next = level_d;
   assign rise_next  = level_d & ~level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the increment and mode buttons into one-cycle request pulses for
// the timekeeping core. Mode wins when both pulses land on the same cycle.
// Define BUTTON_AUTOREPEAT_EN to build hold-to-repeat on the increment channel.
module button_conditioner
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
   parameter int unsigned HOLD_CYCLES     = HoldCyclesDefault,
   parameter int unsigned REPEAT_CYCLES   = RepeatCyclesDefault
) (
   input  logic clock,
   input  logic reset,
   input  logic increment_trigger,
   input  logic counter_trigger,
   output logic inc_pulse,
   output logic mode_pulse,
   output logic inc_level,
   output logic mode_level
);

   logic inc_level_next, inc_rise;
   logic mode_level_next, mode_rise;
   logic inc_fire;
   logic inc_pulse_q, mode_pulse_q;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_inc_debounce (
      .clock      (clock),
      .reset      (reset),
      .raw        (increment_trigger),
      .level      (inc_level),
      .level_next (inc_level_next),
      .rise_next  (inc_rise)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_mode_debounce (
      .clock      (clock),
      .reset      (reset),
      .raw        (counter_trigger),
      .level      (mode_level),
      .level_next (mode_level_next),
      .rise_next  (mode_rise)
   );

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int unsigned HoldCount = max_u(HOLD_CYCLES, REPEAT_CYCLES);
   localparam int unsigned HoldW     = (HoldCount > 1) ? $clog2(HoldCount) : 1;
   localparam logic [HoldW-1:0] HoldLimit   = HoldW'(HOLD_CYCLES - 1);
   localparam logic [HoldW-1:0] RepeatLimit = HoldW'(REPEAT_CYCLES - 1);

   logic [HoldW-1:0] hold_q;
   logic             repeating_q;
   logic             at_limit, repeat_fire;

   // First firing waits the hold time, later ones the repeat interval. No
   // firing on the edge where the debounced level drops.
   always_comb begin
      at_limit    = repeating_q ? (hold_q == RepeatLimit) : (hold_q == HoldLimit);
      repeat_fire = inc_level & inc_level_next & at_limit;
   end

   // Hold timer runs only while increment is held and no mode press intervenes.
   always_ff @(posedge clock) begin
      if (reset || !inc_level || mode_rise) begin
         hold_q      <= '0;
         repeating_q <= 1'b0;
      end else if (at_limit) begin
         hold_q      <= '0;
         repeating_q <= 1'b1;
      end else begin
         hold_q      <= hold_q + 1'b1;
      end
   end

   logic unused_level_next;
   assign unused_level_next = mode_level_next;
   assign inc_fire = inc_rise | repeat_fire;
`else
   logic unused_cfg;
   assign unused_cfg = ^{inc_level_next, mode_level_next, 1'(HOLD_CYCLES), 1'(REPEAT_CYCLES)};
   assign inc_fire   = inc_rise;
`endif

   // Register the request pulses; mode suppresses a coincident increment.
   always_ff @(posedge clock) begin
      if (reset) begin
         inc_pulse_q  <= 1'b0;
         mode_pulse_q <= 1'b0;
      end else begin
         inc_pulse_q  <= inc_fire & ~mode_rise;
         mode_pulse_q <= mode_rise;
      end
   end

   assign inc_pulse  = inc_pulse_q;
   assign mode_pulse = mode_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: reference model checked every cycle, a vector
// table for a clean press/release, and directed multi-cycle corner cases.
module tb_button_conditioner;

   localparam int D    = 4;
   localparam int H    = 20;
   localparam int R    = 8;
   localparam int MAXC = 8192;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic increment_trigger = 1'b0;
   logic counter_trigger = 1'b0;
   logic inc_pulse, mode_pulse, inc_level, mode_level;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: raw input history per channel, indexed by cycle.
   bit rawh [2][MAXC];
   int epoch [2];
   bit m_lvl [2];
   bit exp_ip, exp_mp;
   int hold_start;

   // Observed outputs per cycle.
   bit oip [MAXC];
   bit omp [MAXC];
   bit oil [MAXC];
   bit oml [MAXC];

   typedef struct {
      bit inc;
      bit mode;
      bit ip;
      bit mp;
      bit il;
      bit ml;
   } vec_t;
   vec_t vt [32];

   button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .increment_trigger (increment_trigger),
      .counter_trigger   (counter_trigger),
      .inc_pulse         (inc_pulse),
      .mode_pulse        (mode_pulse),
      .inc_level         (inc_level),
      .mode_level        (mode_level)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0b required=%0b", name, cyc, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // A level is accepted once the synchronized value (raw delayed two cycles)
   // has disagreed with it on each of the last D cycles since the last change.
   task automatic model_edge(input bit r, input bit a, input bit b);
      int k;
      bit raw [2];
      bit nl [2];
      bit all_diff, s, inc_r, mode_r, rep;
      int el;
      k = cyc;
      raw[0] = a;
      raw[1] = b;
      if (r) begin
         for (int ch = 0; ch < 2; ch++) begin
            rawh[ch][k] = 1'b0;
            if (k > 0) rawh[ch][k-1] = 1'b0;
            m_lvl[ch] = 1'b0;
            epoch[ch] = k + 1;
         end
         exp_ip = 1'b0;
         exp_mp = 1'b0;
         hold_start = k + 1;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            rawh[ch][k] = raw[ch];
            nl[ch] = m_lvl[ch];
            if (k - D + 1 >= epoch[ch]) begin
               all_diff = 1'b1;
               for (int j = k - D + 1; j <= k; j++) begin
                  s = (j >= 2) ? rawh[ch][j-2] : 1'b0;
                  if (s == m_lvl[ch]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  nl[ch] = ~m_lvl[ch];
                  epoch[ch] = k + 1;
               end
            end
         end
         inc_r  = nl[0] & ~m_lvl[0];
         mode_r = nl[1] & ~m_lvl[1];
         rep = 1'b0;
         el = 0;
`ifdef BUTTON_AUTOREPEAT_EN
         if (m_lvl[0] && nl[0] && !mode_r) begin
            el = k + 1 - hold_start;
            rep = (el == H) || (el > H && ((el - H) % R) == 0);
         end
`endif
         if (mode_r || inc_r) hold_start = k + 1;
         exp_mp = mode_r;
         exp_ip = (inc_r | rep) & ~mode_r;
         m_lvl[0] = nl[0];
         m_lvl[1] = nl[1];
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge(reset, increment_trigger, counter_trigger);
      cyc++;
      if (cyc >= MAXC - 1) begin
         $display("FAIL cycle_budget actual=%0d required<%0d", cyc, MAXC - 1);
         $fatal(1, "cycle budget exhausted");
      end
      #1;
      oip[cyc] = inc_pulse;
      omp[cyc] = mode_pulse;
      oil[cyc] = inc_level;
      oml[cyc] = mode_level;
      check("model_inc_pulse", inc_pulse, exp_ip);
      check("model_mode_pulse", mode_pulse, exp_mp);
      check("model_inc_level", inc_level, m_lvl[0]);
      check("model_mode_level", mode_level, m_lvl[1]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      increment_trigger = 1'b0;
      counter_trigger = 1'b0;
      repeat (2) step();
      reset = 1'b0;
   endtask

   // sel: 0 inc_pulse, 1 mode_pulse, 2 inc_level
   function automatic int count_obs(input int sel, input int from, input int to);
      int n = 0;
      for (int i = from; i <= to; i++) begin
         case (sel)
            0: n += int'(oip[i]);
            1: n += int'(omp[i]);
            default: n += int'(oil[i]);
         endcase
      end
      return n;
   endfunction

   initial begin
      int b;
      int rem [2];
      bit val [2];

      // Clean press at cycle 10, release at cycle 21.
      for (int k = 0; k < 32; k++) begin
         vt[k].inc  = (k >= 10 && k <= 20);
         vt[k].mode = 1'b0;
         vt[k].ip   = (k == 16);
         vt[k].mp   = 1'b0;
         vt[k].il   = (k >= 16 && k <= 26);
         vt[k].ml   = 1'b0;
      end

      do_reset();
      check("reset_inc_pulse", inc_pulse, 1'b0);
      check("reset_mode_pulse", mode_pulse, 1'b0);
      check("reset_inc_level", inc_level, 1'b0);
      check("reset_mode_level", mode_level, 1'b0);
      for (int k = 0; k < 32; k++) begin
         increment_trigger = vt[k].inc;
         counter_trigger = vt[k].mode;
         check("tbl_inc_pulse", inc_pulse, vt[k].ip);
         check("tbl_mode_pulse", mode_pulse, vt[k].mp);
         check("tbl_inc_level", inc_level, vt[k].il);
         check("tbl_mode_level", mode_level, vt[k].ml);
         step();
      end

      // Bounce 1,0,1,0 then held: last edge at cycle 9, pulse at cycle 15.
      do_reset();
      b = cyc;
      for (int k = 0; k <= 30; k++) begin
         increment_trigger = (k == 5 || k == 7 || k >= 9);
         step();
      end
      check_int("bounce_pulse_count", count_obs(0, b, b + 31), 1);
      check("bounce_pulse_at_15", oip[b + 15], 1'b1);
      check_int("bounce_level_quiet", count_obs(2, b, b + 14), 0);
      check("bounce_level_up", oil[b + 15], 1'b1);

      // Three-cycle blip is rejected.
      do_reset();
      b = cyc;
      for (int k = 0; k <= 25; k++) begin
         increment_trigger = (k >= 3 && k <= 5);
         step();
      end
      check_int("glitch_pulse_count", count_obs(0, b, b + 26), 0);
      check_int("glitch_level_count", count_obs(2, b, b + 26), 0);

      // Both buttons rise at cycle 3: mode wins at cycle 9, no inc pulse.
      do_reset();
      b = cyc;
      for (int k = 0; k <= 20; k++) begin
         increment_trigger = (k >= 3);
         counter_trigger = (k >= 3);
         step();
      end
      check("simul_mode_pulse", omp[b + 9], 1'b1);
      check("simul_inc_pulse", oip[b + 9], 1'b0);
      check_int("simul_inc_count", count_obs(0, b, b + 21), 0);
      check_int("simul_mode_count", count_obs(1, b, b + 21), 1);
      check("simul_levels", oil[b + 9] & oml[b + 9], 1'b1);

      // Reset two cycles into a debounce with the button held.
      do_reset();
      b = cyc;
      for (int k = 0; k <= 25; k++) begin
         increment_trigger = (k >= 2);
         reset = (k == 6 || k == 7);
         step();
      end
      check("rst_mid_out7", oip[b + 7] | oil[b + 7], 1'b0);
      check("rst_mid_out8", oip[b + 8] | oil[b + 8], 1'b0);
      check("rst_mid_pulse_14", oip[b + 14], 1'b1);
      check_int("rst_mid_pulse_count", count_obs(0, b, b + 26), 1);

      // Hold for 60 cycles starting at cycle 2.
      do_reset();
      b = cyc;
      for (int k = 0; k <= 100; k++) begin
         increment_trigger = (k >= 2 && k <= 61);
         step();
      end
      check("hold_first_pulse", oip[b + 8], 1'b1);
`ifdef BUTTON_AUTOREPEAT_EN
      check("hold_repeat_28", oip[b + 28], 1'b1);
      check("hold_repeat_36", oip[b + 36], 1'b1);
      check_int("hold_pulse_count", count_obs(0, b, b + 101), 6);
`else
      check_int("hold_pulse_count", count_obs(0, b, b + 101), 1);
`endif
      check_int("hold_after_release", count_obs(0, b + 67, b + 101), 0);

      // Random bouncy activity with occasional resets, checked by the model.
      do_reset();
      rem[0] = 0;
      rem[1] = 0;
      val[0] = 1'b0;
      val[1] = 1'b0;
      for (int n = 0; n < 2500; n++) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (rem[ch] == 0) begin
               val[ch] = ~val[ch];
               rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                     : int'($urandom_range(5, 40));
            end
            rem[ch]--;
         end
         increment_trigger = val[0];
         counter_trigger = val[1];
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
